// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order pipelined imem requests feeding a small prefetch FIFO,
// with wrong-path kill of outstanding requests after an ID redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [0:0] {FETCH, DRAIN} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   fifo_pc   [FIFO_DEPTH];
   logic [31:0]   fifo_inst [FIFO_DEPTH];

   logic          redirect;
   logic          fire;
   logic          push;
   logic          pop;
   logic [31:0]   occupancy;
   logic [31:0]   target;
   logic [CW-1:0] inflight_nxt;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^branch_addr[1:0];

   assign redirect  = branch_taken && !stall;
   assign target    = {branch_addr[31:2], 2'b00};
   assign occupancy = 32'(inflight) + 32'(count);

   // Credit rule: requests in flight plus buffered words never exceed the FIFO size.
   assign imem_req_valid = !rst && (state == FETCH) && (occupancy < FIFO_DEPTH) && !redirect;
   assign imem_req_addr  = fetch_pc;
   assign fire           = imem_req_valid && imem_req_ready;

   assign push = imem_resp_valid && !redirect && (drop_cnt == '0);
   assign pop  = if_valid && !stall && !redirect;

   assign inflight_nxt = inflight + CW'(fire) - CW'(imem_resp_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= inflight_nxt;
         if (fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (redirect) begin
            // Everything still outstanding, including a same-cycle response, is wrong-path.
            fetch_pc <= target;
            resp_pc  <= target;
            drop_cnt <= inflight_nxt;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            state    <= (inflight_nxt != '0) ? DRAIN : FETCH;
         end else begin
            if (imem_resp_valid && drop_cnt != '0) begin
               drop_cnt <= drop_cnt - CW'(1);
            end
            if (state == DRAIN &&
                (drop_cnt == '0 || (imem_resp_valid && drop_cnt == CW'(1)))) begin
               state <= FETCH;
            end
            if (push) begin
               resp_pc <= resp_pc + 32'd4;
               wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= resp_pc;
         fifo_inst[wr_ptr] <= imem_resp_data;
      end
   end

   assign if_valid = (count != '0);

   always_comb begin
      if_pc   = '0;
      if_inst = NOP;
      if (if_valid) begin
         if_pc   = fifo_pc[rd_ptr];
         if_inst = fifo_inst[rd_ptr];
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, a scripted
// instruction memory, and directed scenarios with literal expectations.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .branch_taken    (branch_taken),
      .branch_addr     (branch_addr),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_inst         (if_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        alive;
   } flight_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   int          checks = 0;
   int          errors = 0;
   logic        chk_en = 1'b0;

   // Reference model: requests in flight (oldest first) and buffered words.
   flight_t     m_flight[$];
   entry_t      m_buf[$];
   logic [31:0] m_req_pc;

   // Memory side and observation logs.
   logic [31:0] mem_q[$];
   logic [31:0] fire_log[$];
   logic [31:0] pop_log[$];
   logic        dut_fire;
   logic [31:0] dut_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic m_draining();
      foreach (m_flight[i]) if (!m_flight[i].alive) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_req_valid();
      return !m_draining() && (m_flight.size() + m_buf.size() < FIFO_DEPTH) &&
             !(branch_taken && !stall);
   endfunction

   task automatic model_reset();
      m_flight.delete();
      m_buf.delete();
      m_req_pc = RESET_PC;
   endtask

   task automatic model_edge();
      logic    redir;
      logic    fire;
      logic    pop;
      flight_t f;
      redir = branch_taken && !stall;
      fire  = m_req_valid() && imem_req_ready;
      pop   = (m_buf.size() != 0) && !stall && !redir;
      if (pop) void'(m_buf.pop_front());
      if (imem_resp_valid) begin
         if (m_flight.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_expected: got response with 0 expected in flight at %0t", $time);
         end else begin
            f = m_flight.pop_front();
            if (f.alive && !redir) m_buf.push_back('{pc: f.pc, inst: imem_resp_data});
         end
      end
      if (fire) begin
         m_flight.push_back('{pc: m_req_pc, alive: 1'b1});
         m_req_pc = m_req_pc + 32'd4;
      end
      if (redir) begin
         foreach (m_flight[i]) m_flight[i].alive = 1'b0;
         m_buf.delete();
         m_req_pc = {branch_addr[31:2], 2'b00};
      end
   endtask

   // One clock cycle: drive inputs, sample at negedge, advance model and memory at posedge.
   task automatic step(input logic st, input logic br, input logic [31:0] ba, input logic rdy,
                       input logic men);
      stall          = st;
      branch_taken   = br;
      branch_addr    = ba;
      imem_req_ready = rdy;
      if (men && mem_q.size() != 0) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = inst_of(mem_q[0]);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      dut_fire = imem_req_valid && imem_req_ready;
      dut_addr = imem_req_addr;
      if (dut_fire) fire_log.push_back(dut_addr);
      if (if_valid && !stall && !branch_taken) pop_log.push_back(if_pc);
      @(posedge clk);
      model_edge();
      if (imem_resp_valid) void'(mem_q.pop_front());
      if (dut_fire) mem_q.push_back(dut_addr);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
      chk({tag, "_if_pc"}, if_pc, 32'd0);
      chk({tag, "_if_inst"}, if_inst, NOP);
      chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("req_valid", 32'(imem_req_valid), 32'(m_req_valid()));
         chk("req_addr", imem_req_addr, m_req_pc);
         chk("if_valid", 32'(if_valid), 32'(m_buf.size() != 0));
         chk("if_pc", if_pc, (m_buf.size() != 0) ? m_buf[0].pc : 32'd0);
         chk("if_inst", if_inst, (m_buf.size() != 0) ? m_buf[0].inst : NOP);
      end
   end

   initial begin
      int          fl_idx;
      int          pl_idx;
      logic [31:0] exp_head;
      rst             = 1'b0;
      stall           = 1'b0;
      branch_taken    = 1'b0;
      branch_addr     = 32'h0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      model_reset();
      #1 rst = 1'b1;
      #1 chk_reset_values("por");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // Zero-wait memory after reset.
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("first_if_valid_low", 32'(if_valid), 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("first_if_valid_high", 32'(if_valid), 32'd1);
      chk("first_if_pc", if_pc, 32'h0);
      run(6);
      chk("fire0", fire_log[0], 32'h0);
      chk("fire1", fire_log[1], 32'h4);
      chk("fire2", fire_log[2], 32'h8);

      // Stall held three cycles, then resume.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      run(4);
      for (int i = 0; i < pop_log.size(); i++) chk("seq_pc", pop_log[i], 32'(i * 4));

      // Starve responses so two requests are in flight, then redirect to 0x103.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("two_in_flight", 32'(mem_q.size()), 32'd2);
      fl_idx = fire_log.size();
      pl_idx = pop_log.size();
      step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
      chk("redir_if_valid", 32'(if_valid), 32'd0);
      chk("redir_if_inst", if_inst, NOP);
      chk("redir_req_addr", imem_req_addr, 32'h100);
      run(8);
      chk("redir_first_fire", fire_log[fl_idx], 32'h100);
      chk("redir_first_pop", pop_log[pl_idx], 32'h100);

      // Branch while stalled is ignored; head entry retained.
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      exp_head = (m_buf.size() != 0) ? m_buf[0].pc : 32'hFFFF_FFFF;
      step(1'b1, 1'b1, 32'h0000_4000, 1'b1, 1'b1);
      chk("stall_br_valid", 32'(if_valid), 32'd1);
      chk("stall_br_pc", if_pc, exp_head);
      run(3);

      // Response coincides with a redirect while exactly one request is in flight.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("one_in_flight", 32'(mem_q.size()), 32'd1);
      fl_idx = fire_log.size();
      pl_idx = pop_log.size();
      step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
      chk("same_cyc_if_valid", 32'(if_valid), 32'd0);
      chk("same_cyc_req_addr", imem_req_addr, 32'h200);
      run(5);
      chk("same_cyc_first_fire", fire_log[fl_idx], 32'h200);
      chk("same_cyc_first_pop", pop_log[pl_idx], 32'h200);

      // Asynchronous reset mid-cycle with work buffered and in flight.
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1 chk_reset_values("mid_rst");
      mem_q.delete();
      model_reset();
      imem_resp_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      fl_idx = fire_log.size();
      pl_idx = pop_log.size();
      run(6);
      chk("rst_first_fire", fire_log[fl_idx], RESET_PC);
      chk("rst_first_pop", pop_log[pl_idx], RESET_PC);
      chk("rst_second_pop", pop_log[pl_idx + 1], RESET_PC + 32'd4);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
